// File: rtl/uart_program_loader_if.sv
// Bus between the UART program loader and its surroundings: serial input,
// program-memory write port and CPU release/status flags.
interface uart_program_loader_if;
  logic       RX;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_run;
  logic       load_done;
  logic       frame_err;
  logic [5:0] byte_count;

  modport master (
    input  RX,
    output mem_we, mem_addr, mem_wdata, cpu_run, load_done, frame_err, byte_count
  );

  modport slave (
    output RX,
    input  mem_we, mem_addr, mem_wdata, cpu_run, load_done, frame_err, byte_count
  );
endinterface

// File: rtl/uart_program_loader.sv
// Receives a length-prefixed program over an 8N1 UART line, writes it into
// program memory and then releases the CPU; any framing fault locks it out.
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 24,
  parameter int MEM_DEPTH    = 32
) (
  input  logic                   Clk,
  input  logic                   Reset,
  uart_program_loader_if.master  bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [7:0]    DEPTH8 = 8'(MEM_DEPTH);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3} rstate_t;
  typedef enum logic [1:0] {L_LEN = 2'd0, L_LOAD = 2'd1, L_RUN = 2'd2, L_ERR = 2'd3} lstate_t;

  logic [1:0]    r_sync;
  rstate_t       r_rstate, w_rstate_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [2:0]    r_bit_idx, w_bit_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_rxs, w_bit_tick, w_rx_valid, w_rx_ferr, w_len_ok;

  lstate_t       r_lstate, w_lstate_nxt;
  logic          r_mem_we, w_mem_we;
  logic [4:0]    r_mem_addr, w_mem_addr;
  logic [7:0]    r_mem_wdata, w_mem_wdata;
  logic          r_cpu_run, w_cpu_run;
  logic          r_load_done, w_load_done;
  logic          r_frame_err, w_frame_err;
  logic [5:0]    r_byte_count, w_byte_count;
  logic [5:0]    r_len, w_len;

  assign w_rxs      = r_sync[1];
  assign w_bit_tick = (r_timer == T_LAST);
  assign w_len_ok   = (r_shift != 8'd0) && (r_shift <= DEPTH8);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], bus.RX};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rstate  <= R_IDLE;
      r_timer   <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_timer   <= w_timer_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (!w_rxs) w_rstate_nxt = R_START; else w_rstate_nxt = R_IDLE;
      R_START: begin
        if (r_timer == T_HALF) begin
          if (w_rxs) w_rstate_nxt = R_IDLE; else w_rstate_nxt = R_DATA;
        end else begin
          w_rstate_nxt = R_START;
        end
      end
      R_DATA:  if (w_bit_tick && (r_bit_idx == 3'd7)) w_rstate_nxt = R_STOP; else w_rstate_nxt = R_DATA;
      R_STOP:  if (w_bit_tick) w_rstate_nxt = R_IDLE; else w_rstate_nxt = R_STOP;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Stop-bit result is a combinational strobe so the loader can register the write on the same edge.
  always_comb begin
    w_timer_nxt   = r_timer + T_ONE;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_rx_valid    = 1'b0;
    w_rx_ferr     = 1'b0;
    case (r_rstate)
      R_IDLE:  w_timer_nxt = '0;
      R_START: begin
        if (r_timer == T_HALF) begin
          w_timer_nxt   = '0;
          w_bit_idx_nxt = 3'd0;
        end else begin
          w_timer_nxt = r_timer + T_ONE;
        end
      end
      R_DATA: begin
        if (w_bit_tick) begin
          w_timer_nxt   = '0;
          w_shift_nxt   = {w_rxs, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
        end else begin
          w_timer_nxt = r_timer + T_ONE;
        end
      end
      R_STOP: begin
        if (w_bit_tick) begin
          w_timer_nxt = '0;
          w_rx_valid  = w_rxs;
          w_rx_ferr   = ~w_rxs;
        end else begin
          w_timer_nxt = r_timer + T_ONE;
        end
      end
      default: w_timer_nxt = '0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_lstate     <= L_LEN;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 5'd0;
      r_mem_wdata  <= 8'd0;
      r_cpu_run    <= 1'b0;
      r_load_done  <= 1'b0;
      r_frame_err  <= 1'b0;
      r_byte_count <= 6'd0;
      r_len        <= 6'd0;
    end else begin
      r_lstate     <= w_lstate_nxt;
      r_mem_we     <= w_mem_we;
      r_mem_addr   <= w_mem_addr;
      r_mem_wdata  <= w_mem_wdata;
      r_cpu_run    <= w_cpu_run;
      r_load_done  <= w_load_done;
      r_frame_err  <= w_frame_err;
      r_byte_count <= w_byte_count;
      r_len        <= w_len;
    end
  end

  always_comb begin
    w_lstate_nxt = r_lstate;
    case (r_lstate)
      L_LEN: begin
        if (w_rx_ferr)       w_lstate_nxt = L_ERR;
        else if (w_rx_valid) w_lstate_nxt = w_len_ok ? L_LOAD : L_ERR;
        else                 w_lstate_nxt = L_LEN;
      end
      L_LOAD: begin
        if (w_rx_ferr)                    w_lstate_nxt = L_ERR;
        else if (r_byte_count == r_len)   w_lstate_nxt = L_RUN;
        else                              w_lstate_nxt = L_LOAD;
      end
      L_RUN:   w_lstate_nxt = L_RUN;
      L_ERR:   w_lstate_nxt = L_ERR;
      default: w_lstate_nxt = L_ERR;
    endcase
  end

  // Count reaching the length wins over a new byte, so the count saturates at L.
  always_comb begin
    w_mem_we     = 1'b0;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_cpu_run    = r_cpu_run;
    w_load_done  = r_load_done;
    w_frame_err  = r_frame_err;
    w_byte_count = r_byte_count;
    w_len        = r_len;
    case (r_lstate)
      L_LEN: begin
        if (w_rx_ferr)                   w_frame_err = 1'b1;
        else if (w_rx_valid && w_len_ok) w_len = r_shift[5:0];
        else                             w_len = r_len;
      end
      L_LOAD: begin
        if (w_rx_ferr) begin
          w_frame_err = 1'b1;
        end else if (r_byte_count == r_len) begin
          w_cpu_run   = 1'b1;
          w_load_done = 1'b1;
        end else if (w_rx_valid) begin
          w_mem_we     = 1'b1;
          w_mem_addr   = r_byte_count[4:0];
          w_mem_wdata  = r_shift;
          w_byte_count = r_byte_count + 6'd1;
        end else begin
          w_mem_we = 1'b0;
        end
      end
      L_RUN: begin
        w_cpu_run   = 1'b1;
        w_load_done = 1'b1;
      end
      L_ERR: begin
        w_cpu_run = 1'b0;
        if (w_rx_ferr) w_frame_err = 1'b1; else w_frame_err = r_frame_err;
      end
      default: w_cpu_run = 1'b0;
    endcase
  end

  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.cpu_run    = r_cpu_run;
  assign bus.load_done  = r_load_done;
  assign bus.frame_err  = r_frame_err;
  assign bus.byte_count = r_byte_count;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: serial frames in, write strobes and
// status flags checked against hand-computed values.
module tb_uart_program_loader;
  localparam int BIT = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   base;

  uart_program_loader_if bus();

  uart_program_loader #(.CLKS_PER_BIT(BIT), .MEM_DEPTH(32)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         wr_n = 0;
  int         run_cyc = -1;
  logic       prev_run = 1'b0;
  logic [4:0] wr_addr [256];
  logic [7:0] wr_data [256];
  int         wr_cyc  [256];

  // Write-strobe recorder: every cycle with mem_we high is logged as one write.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.mem_we === 1'b1) begin
      wr_addr[wr_n[7:0]] = bus.mem_addr;
      wr_data[wr_n[7:0]] = bus.mem_wdata;
      wr_cyc[wr_n[7:0]]  = cyc;
      wr_n = wr_n + 1;
    end
    if (bus.cpu_run === 1'b1 && prev_run === 1'b0) run_cyc = cyc;
    prev_run = bus.cpu_run;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    bus.RX = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    bus.RX = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.RX = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    {31'd0, bus.mem_we},    32'd0);
    chk({tag, "_addr"},  {27'd0, bus.mem_addr},  32'd0);
    chk({tag, "_wdata"}, {24'd0, bus.mem_wdata}, 32'd0);
    chk({tag, "_run"},   {31'd0, bus.cpu_run},   32'd0);
    chk({tag, "_done"},  {31'd0, bus.load_done}, 32'd0);
    chk({tag, "_ferr"},  {31'd0, bus.frame_err}, 32'd0);
    chk({tag, "_cnt"},   {26'd0, bus.byte_count}, 32'd0);
  endtask

  initial begin
    bus.RX = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    #1;

    // Three-byte program
    base = wr_n;
    send_byte(8'h03, 1'b1);
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hC3, 1'b1);
    #1;
    chk("p3_nwr", wr_n - base, 32'd3);
    chk("p3_a0", {27'd0, wr_addr[base]},     32'd0);
    chk("p3_d0", {24'd0, wr_data[base]},     32'hA1);
    chk("p3_a1", {27'd0, wr_addr[base + 1]}, 32'd1);
    chk("p3_d1", {24'd0, wr_data[base + 1]}, 32'hB2);
    chk("p3_a2", {27'd0, wr_addr[base + 2]}, 32'd2);
    chk("p3_d2", {24'd0, wr_data[base + 2]}, 32'hC3);
    chk("p3_run_lat", run_cyc, wr_cyc[base + 2] + 1);
    chk("p3_run",  {31'd0, bus.cpu_run},   32'd1);
    chk("p3_done", {31'd0, bus.load_done}, 32'd1);
    chk("p3_cnt",  {26'd0, bus.byte_count}, 32'd3);
    chk("p3_hold_addr",  {27'd0, bus.mem_addr},  32'd2);
    chk("p3_hold_wdata", {24'd0, bus.mem_wdata}, 32'hC3);
    chk("p3_ferr", {31'd0, bus.frame_err}, 32'd0);
    send_byte(8'h77, 1'b1);
    send_byte(8'h12, 1'b0);
    repeat (12 * BIT) @(negedge clk);
    #1;
    chk("p3_run_nowr", wr_n - base, 32'd3);
    chk("p3_run_cnt",  {26'd0, bus.byte_count}, 32'd3);
    chk("p3_run_ferr_ignored", {31'd0, bus.frame_err}, 32'd0);
    chk("p3_run_stays", {31'd0, bus.cpu_run}, 32'd1);

    // Full 32-byte program
    do_reset();
    chk_all_zero("rst2");
    base = wr_n;
    send_byte(8'h20, 1'b1);
    for (int i = 0; i < 32; i++) send_byte(8'(i), 1'b1);
    #1;
    chk("p32_nwr", wr_n - base, 32'd32);
    for (int i = 0; i < 32; i++) begin
      chk("p32_addr", {27'd0, wr_addr[base + i]}, 32'(i));
      chk("p32_data", {24'd0, wr_data[base + i]}, 32'(i));
    end
    chk("p32_run", {31'd0, bus.cpu_run},    32'd1);
    chk("p32_cnt", {26'd0, bus.byte_count}, 32'd32);
    send_byte(8'hEE, 1'b1);
    #1;
    chk("p32_nowrap", wr_n - base, 32'd32);
    chk("p32_cnt_sat", {26'd0, bus.byte_count}, 32'd32);

    // Illegal lengths 0x00 and 0x21
    do_reset();
    base = wr_n;
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    #1;
    chk("len0_nwr", wr_n - base, 32'd0);
    chk("len0_run", {31'd0, bus.cpu_run},   32'd0);
    chk("len0_done", {31'd0, bus.load_done}, 32'd0);
    chk("len0_ferr", {31'd0, bus.frame_err}, 32'd0);
    do_reset();
    base = wr_n;
    send_byte(8'h21, 1'b1);
    send_byte(8'h11, 1'b1);
    repeat (20 * BIT) @(negedge clk);
    #1;
    chk("len21_nwr", wr_n - base, 32'd0);
    chk("len21_run", {31'd0, bus.cpu_run},    32'd0);
    chk("len21_cnt", {26'd0, bus.byte_count}, 32'd0);

    // Frame error during load
    do_reset();
    base = wr_n;
    send_byte(8'h02, 1'b1);
    send_byte(8'h5A, 1'b0);
    repeat (12 * BIT) @(negedge clk);
    #1;
    chk("ferr_flag", {31'd0, bus.frame_err}, 32'd1);
    chk("ferr_nwr",  wr_n - base, 32'd0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    #1;
    chk("ferr_after_nwr", wr_n - base, 32'd0);
    chk("ferr_run",   {31'd0, bus.cpu_run},   32'd0);
    chk("ferr_stick", {31'd0, bus.frame_err}, 32'd1);

    // Short idle glitch, then a normal one-byte load
    do_reset();
    base = wr_n;
    bus.RX = 1'b0;
    repeat (5) @(negedge clk);
    bus.RX = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    #1;
    chk("glitch_nwr", wr_n - base, 32'd0);
    chk("glitch_ferr", {31'd0, bus.frame_err}, 32'd0);
    chk("glitch_cnt",  {26'd0, bus.byte_count}, 32'd0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h3C, 1'b1);
    #1;
    chk("glitch_load_nwr", wr_n - base, 32'd1);
    chk("glitch_load_addr", {27'd0, wr_addr[base]}, 32'd0);
    chk("glitch_load_data", {24'd0, wr_data[base]}, 32'h3C);
    chk("glitch_load_run", {31'd0, bus.cpu_run}, 32'd1);

    // Reset in the middle of the second data byte
    do_reset();
    base = wr_n;
    send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1);
    #1;
    chk("abort_first_wr", wr_n - base, 32'd1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("abort");
    bus.RX = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = wr_n;
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b1);
    #1;
    chk("reload_nwr",  wr_n - base, 32'd1);
    chk("reload_addr", {27'd0, wr_addr[base]}, 32'd0);
    chk("reload_data", {24'd0, wr_data[base]}, 32'h55);
    chk("reload_run",  {31'd0, bus.cpu_run},    32'd1);
    chk("reload_cnt",  {26'd0, bus.byte_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_program_loader.md
UART_PROGRAM_LOADER -- requirements
Module: uart_program_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 24, SHALL set the clock cycles per UART bit period.
REQ-002 Parameter MEM_DEPTH, default 32, SHALL set the program memory depth (address width 5).
REQ-003 Port Clk, input, 1 bit: the single clock; all logic SHALL be rising-edge triggered.
REQ-004 Port Reset, input, 1 bit: SHALL be asynchronous and active-high.
REQ-005 Port RX, input, 1 bit: UART serial line (8N1, LSB first, idle high).
REQ-006 Port mem_we, output, 1 bit: program memory write strobe, one cycle per byte.
REQ-007 Port mem_addr, output, 5 bits: program memory write address.
REQ-008 Port mem_wdata, output, 8 bits: program memory write data.
REQ-009 Port cpu_run, output, 1 bit: high releases the downstream CPU from hold.
REQ-010 Port load_done, output, 1 bit: high once the complete program is written.
REQ-011 Port frame_err, output, 1 bit: sticky error flag.
REQ-012 Port byte_count, output, 6 bits: number of program bytes written so far.

Function
REQ-013 RX SHALL pass through a 2-flop synchronizer; all following timing refers to the synchronized signal (rxs).
REQ-014 Receiver FSM SHALL have states R_IDLE, R_START, R_DATA and R_STOP.
REQ-015 R_IDLE: rxs=0 SHALL enter R_START and clear the bit timer.
REQ-016 R_START: at timer = CLKS_PER_BIT/2 (12), rxs=1 SHALL return to R_IDLE (glitch) and rxs=0 SHALL enter R_DATA.
REQ-017 R_DATA: eight samples SHALL be taken every CLKS_PER_BIT cycles, shifted in LSB first.
REQ-018 R_STOP: one CLKS_PER_BIT later, rxs=1 SHALL produce a valid byte and rxs=0 SHALL produce a frame error; both SHALL return to R_IDLE.
REQ-019 Loader FSM SHALL have states L_LEN, L_LOAD, L_RUN and L_ERR.
REQ-020 L_LEN: the first valid byte is length L; L in 1..32 SHALL enter L_LOAD, and L=0 or L>32 SHALL enter L_ERR.
REQ-021 L_LOAD: each valid byte SHALL pulse mem_we for exactly one cycle, the cycle after the stop sample.
REQ-022 Each write SHALL use mem_wdata = byte and mem_addr = byte_count, then increment byte_count.
REQ-023 When byte_count reaches L, the next cycle SHALL enter L_RUN and set load_done=1 and cpu_run=1.
REQ-024 L_RUN SHALL be terminal until Reset; further RX bytes are received but SHALL NOT cause writes.
REQ-025 A frame error in any loader state except L_RUN SHALL set frame_err=1 and enter L_ERR; in L_RUN it SHALL be ignored.
REQ-026 L_ERR SHALL hold cpu_run=0 and mem_we=0 until Reset.
REQ-027 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.
REQ-028 byte_count SHALL saturate at L and never wrap.

Reset
REQ-029 While Reset=1: receiver SHALL be in R_IDLE, loader in L_LEN, and the synchronizer SHALL be preset to 1.
REQ-030 While Reset=1: mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, load_done=0, frame_err=0, byte_count=0.
REQ-031 Reset asserted mid-byte or mid-load SHALL abort immediately; the partial program is discarded and reloading starts from L_LEN.

Verification
REQ-032 Length 0x03, then 0xA1, 0xB2, 0xC3 at 24 clk/bit -> three mem_we pulses at addr 0/1/2 with data A1/B2/C3; cpu_run=1 and load_done=1 one cycle after the third write; byte_count=3.
REQ-033 Length 0x20, then 32 bytes 0x00..0x1F -> addr 31 receives 0x1F; cpu_run=1; byte_count=32; no address wrap.
REQ-034 Length 0x00, or length 0x21 -> L_ERR entered; no mem_we; cpu_run stays 0 indefinitely.
REQ-035 Length 0x02, then a byte with stop bit driven 0 -> frame_err=1; no write for that byte; later valid bytes produce no writes.
REQ-036 RX low pulse of 5 cycles while idle -> no byte received and no state change; a valid frame sent afterwards is received correctly.
REQ-037 Reset pulsed during the second data byte of a 3-byte load -> all outputs return to 0; a fresh length 0x01 + 0x55 load writes 0x55 at addr 0 and sets cpu_run=1.
